// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM state encodings and the
// supported oversampling ratios.
package uart_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;
    localparam logic [2:0] ST_ERR_CHK = 3'd5;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    function automatic logic prescale_legal(input logic [5:0] p);
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Oversample edge counter and data-bit counter for the RX sequencer.
// edge_cnt wraps at prescale-1 (bit_end); bit_cnt advances on request.
module uart_edge_bit_counter #(
    parameter int BIT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             edge_clr,
    input  logic             bit_clr,
    input  logic             bit_inc,
    input  logic [5:0]       prescale,
    output logic [5:0]       edge_cnt,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             bit_end
);

    logic [5:0]       edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

    assign bit_end  = (edge_cnt_q == (prescale - 6'd1));
    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (edge_clr) begin
            edge_cnt_d = 6'd0;
        end else if (cnt_en) begin
            edge_cnt_d = bit_end ? 6'd0 : (edge_cnt_q + 6'd1);
        end else begin
            edge_cnt_d = edge_cnt_q;
        end
        if (bit_clr) begin
            bit_cnt_d = '0;
        end else if (bit_inc) begin
            bit_cnt_d = bit_cnt_q + {{(BIT_W-1){1'b0}}, 1'b1};
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_q <= 6'd0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, START/DATA/PARITY/STOP walk and
// one-cycle enables for the checkers and deserializer.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       PAR_EN,
    input  logic [5:0] prescale,
    input  logic       par_err,
    input  logic       strt_glitch,
    input  logic       stp_err,
    output logic       dat_samp_en,
    output logic [5:0] edge_cnt,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid
);

    localparam int               BIT_W    = $clog2(DATA_WIDTH) + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    logic [2:0]       state_q, state_d;
    logic             par_en_q, par_en_d;
    logic [5:0]       prescale_q, prescale_d;
    logic [BIT_W-1:0] bit_cnt_s;
    logic             bit_end_s;
    logic             first_data_s;
    logic             cnt_en_s, edge_clr_s, bit_clr_s, bit_inc_s;

    // Only the very first DATA cycle sees both counters at zero.
    assign first_data_s = (edge_cnt == 6'd0) && (bit_cnt_s == '0);

    always_comb begin
        state_d    = state_q;
        par_en_d   = par_en_q;
        prescale_d = prescale_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_in) begin
                    state_d    = ST_START;
                    par_en_d   = PAR_EN;
                    prescale_d = prescale_legal(prescale) ? prescale : PRESCALE_8;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) state_d = ST_DATA;
                else           state_d = ST_START;
            end
            ST_DATA: begin
                if (first_data_s && strt_glitch) begin
                    state_d = ST_IDLE;
                end else if (bit_end_s && (bit_cnt_s == LAST_BIT)) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) state_d = ST_STOP;
                else           state_d = ST_PARITY;
            end
            ST_STOP: begin
                if (bit_end_s) state_d = ST_ERR_CHK;
                else           state_d = ST_STOP;
            end
            ST_ERR_CHK: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Counter control is keyed on the next state so edge_cnt already reads 0
    // in the first IDLE/ERR_CHK cycle.
    assign cnt_en_s   = (state_q != ST_IDLE) && (state_q != ST_ERR_CHK);
    assign edge_clr_s = (state_d == ST_IDLE) || (state_d == ST_ERR_CHK);
    assign bit_clr_s  = (state_d == ST_DATA) && (state_q != ST_DATA);
    assign bit_inc_s  = (state_q == ST_DATA) && bit_end_s;

    uart_edge_bit_counter #(
        .BIT_W (BIT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .cnt_en   (cnt_en_s),
        .edge_clr (edge_clr_s),
        .bit_clr  (bit_clr_s),
        .bit_inc  (bit_inc_s),
        .prescale (prescale_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt_s),
        .bit_end  (bit_end_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            par_en_q   <= 1'b0;
            prescale_q <= PRESCALE_8;
        end else begin
            state_q    <= state_d;
            par_en_q   <= par_en_d;
            prescale_q <= prescale_d;
        end
    end

    // Enables are decoded from flops only; data_valid must see the checker
    // flags registered on the stop-bit edge, so it cannot be a further flop.
    always_comb begin
        dat_samp_en = (state_q != ST_IDLE);
        strt_chk_en = (state_q == ST_START)  && bit_end_s;
        deser_en    = (state_q == ST_DATA)   && bit_end_s;
        par_chk_en  = (state_q == ST_PARITY) && bit_end_s;
        stp_chk_en  = (state_q == ST_STOP)   && bit_end_s;
        data_valid  = (state_q == ST_ERR_CHK) && !stp_err && !(par_en_q && par_err);
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives whole frames on rx_in and checks
// enable counts and cycle positions relative to start detection.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       PAR_EN;
    logic [5:0] prescale;
    logic       par_err;
    logic       strt_glitch;
    logic       stp_err;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    int n_strt, strt_last, n_deser, deser_first, deser_last;
    int n_par, par_last, n_stp, stp_last, n_dv, dv_first, dv_last;
    int excl_viol;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .PAR_EN      (PAR_EN),
        .prescale    (prescale),
        .par_err     (par_err),
        .strt_glitch (strt_glitch),
        .stp_err     (stp_err),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .strt_chk_en (strt_chk_en),
        .deser_en    (deser_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record each pulse with its cycle index relative to start detection.
    always @(negedge clk) begin
        if (rst) begin
            int rel;
            rel = cyc - start_cyc;
            if (strt_chk_en) begin n_strt++; strt_last = rel; end
            if (deser_en) begin
                if (n_deser == 0) deser_first = rel;
                n_deser++;
                deser_last = rel;
            end
            if (par_chk_en) begin n_par++; par_last = rel; end
            if (stp_chk_en) begin n_stp++; stp_last = rel; end
            if (data_valid) begin
                if (n_dv == 0) dv_first = rel;
                n_dv++;
                dv_last = rel;
            end
            if ((int'(strt_chk_en) + int'(deser_en) + int'(par_chk_en) +
                 int'(stp_chk_en) + int'(data_valid)) > 1)
                excl_viol = 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        n_strt = 0; strt_last = -1; n_deser = 0; deser_first = -1; deser_last = -1;
        n_par = 0; par_last = -1; n_stp = 0; stp_last = -1;
        n_dv = 0; dv_first = -1; dv_last = -1; excl_viol = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_level(input logic v, input int n);
        rx_in = v;
        repeat (n) tick();
    endtask

    task automatic start_frame(input int p);
        start_cyc = cyc;
        drive_level(1'b0, p);
    endtask

    // Data bits LSB first, optional parity, stop bit, then ERR_CHK + one IDLE cycle.
    task automatic send_bits(input logic [7:0] data, input int p,
                             input logic has_par, input logic par_bit);
        for (int i = 0; i < 8; i++) drive_level(data[i], p);
        if (has_par) drive_level(par_bit, p);
        drive_level(1'b1, p);
        drive_level(1'b1, 2);
    endtask

    initial begin
        rst = 1'b0; rx_in = 1'b1; PAR_EN = 1'b0; prescale = 6'd8;
        par_err = 1'b0; strt_glitch = 1'b0; stp_err = 1'b0;
        clr_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid}), 0);
        chk("reset_edge_cnt", int'(edge_cnt), 0);
        rst = 1'b1;
        repeat (3) tick();

        // 1: P=8 with parity, 0xA5 (even parity bit 0)
        clr_mon(); PAR_EN = 1'b1; prescale = 6'd8;
        start_frame(8);
        send_bits(8'hA5, 8, 1'b1, 1'b0);
        chk("t1_strt_cnt", n_strt, 1);
        chk("t1_strt_cyc", strt_last, 8);
        chk("t1_deser_cnt", n_deser, 8);
        chk("t1_deser_first", deser_first, 16);
        chk("t1_deser_last", deser_last, 72);
        chk("t1_par_cnt", n_par, 1);
        chk("t1_par_cyc", par_last, 80);
        chk("t1_stp_cyc", stp_last, 88);
        chk("t1_dv_cnt", n_dv, 1);
        chk("t1_dv_cyc", dv_last, 89);
        chk("t1_idle_samp", int'(dat_samp_en), 0);
        chk("t1_excl", excl_viol, 0);

        // 2: P=16 without parity, 0x3C
        clr_mon(); PAR_EN = 1'b0; prescale = 6'd16;
        start_frame(16);
        send_bits(8'h3C, 16, 1'b0, 1'b0);
        chk("t2_par_cnt", n_par, 0);
        chk("t2_deser_last", deser_last, 144);
        chk("t2_stp_cyc", stp_last, 160);
        chk("t2_dv_cyc", dv_last, 161);
        chk("t2_excl", excl_viol, 0);

        // 3: wrong parity bit, parity checker flags an error
        clr_mon(); PAR_EN = 1'b1; prescale = 6'd8; par_err = 1'b1;
        start_frame(8);
        send_bits(8'hA5, 8, 1'b1, 1'b1);
        chk("t3_par_cnt", n_par, 1);
        chk("t3_stp_cyc", stp_last, 88);
        chk("t3_dv_cnt", n_dv, 0);
        chk("t3_idle_samp", int'(dat_samp_en), 0);
        par_err = 1'b0;

        // 4: start glitch, frame dropped in the first DATA cycle
        clr_mon(); PAR_EN = 1'b0; prescale = 6'd8; strt_glitch = 1'b1;
        start_cyc = cyc;
        drive_level(1'b0, 2);
        drive_level(1'b1, 7);
        chk("t4_first_data_edge", int'(edge_cnt), 0);
        chk("t4_first_data_samp", int'(dat_samp_en), 1);
        tick();
        chk("t4_strt_cyc", strt_last, 8);
        chk("t4_back_idle", int'(dat_samp_en), 0);
        repeat (20) tick();
        chk("t4_deser_cnt", n_deser, 0);
        chk("t4_dv_cnt", n_dv, 0);
        strt_glitch = 1'b0;

        // 5: reset in the middle of data bit 4, then a fresh frame
        clr_mon(); PAR_EN = 1'b0; prescale = 6'd8;
        start_frame(8);
        for (int i = 0; i < 4; i++) drive_level(1'b1, 8);
        drive_level(1'b0, 4);
        chk("t5_pre_rst_edge", int'(edge_cnt), 3);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_outputs", int'({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid}), 0);
        chk("t5_rst_edge_cnt", int'(edge_cnt), 0);
        rx_in = 1'b1;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("t5_dv_aborted", n_dv, 0);
        clr_mon();
        start_frame(8);
        send_bits(8'h5A, 8, 1'b0, 1'b0);
        chk("t5_deser_cnt", n_deser, 8);
        chk("t5_dv_cnt", n_dv, 1);
        chk("t5_dv_cyc", dv_last, 81);

        // 6: back-to-back, config changed mid frame 1 applies only to frame 2
        clr_mon(); PAR_EN = 1'b0; prescale = 6'd32;
        start_cyc = cyc;
        drive_level(1'b0, 1);
        prescale = 6'd8; PAR_EN = 1'b1;
        drive_level(1'b0, 31);
        send_bits(8'h96, 32, 1'b0, 1'b0);
        drive_level(1'b0, 8);
        send_bits(8'hC3, 8, 1'b1, 1'b0);
        chk("t6_dv_cnt", n_dv, 2);
        chk("t6_dv_first", dv_first, 321);
        chk("t6_dv_last", dv_last, 411);
        chk("t6_strt_last", strt_last, 330);
        chk("t6_par_cnt", n_par, 1);
        chk("t6_par_cyc", par_last, 402);
        chk("t6_deser_cnt", n_deser, 16);
        chk("t6_excl", excl_viol, 0);

        // 7: illegal prescale runs at 8; par_err ignored without parity
        clr_mon(); PAR_EN = 1'b0; prescale = 6'd12; par_err = 1'b1;
        start_frame(8);
        send_bits(8'h01, 8, 1'b0, 1'b0);
        chk("t7_stp_cyc", stp_last, 80);
        chk("t7_dv_cyc", dv_last, 81);
        par_err = 1'b0; prescale = 6'd8;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
